data_memory_arbiter: RTL



---
 rtl/data_memory_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/data_memory_arbiter.sv
//-----------------------------------------------------------------------------
// data_memory_arbiter
//
// Purpose:
//   Shares one single-port synchronous data memory between the CPU memory
//   stage and an external requester (DMA / program loader), one access per
//   cycle. The CPU normally wins. An optional starvation guard bounds how long
//   the external port can be kept waiting. The block stalls the CPU when it
//   loses arbitration. It also tags each read so that the one-cycle-latency
//   return is flagged for the port that issued it.
//
// Build option:
//   ARB_STARVE_GUARD_EN
//     defined   : after STARVE_LIMIT consecutive contended CPU grants, the
//                 external port wins the next contended cycle.
//     undefined : strict CPU priority. No starvation counter is built, and
//                 the external port is granted only when the CPU is idle.
//
// Parameters:
//   STARVE_LIMIT  contended CPU grants before the external port is forced in
//                 (must be >= 1; only used when the guard is built)
//
// Ports:
//   iClk, iRst     clock (rising edge) and asynchronous active-high reset
//   iCpu*          CPU request: req, we, addr, wdata, byte enables
//   oCpuStall      CPU request not granted this cycle
//   oCpuRValid     oCpuRData carries CPU load data this cycle
//   oCpuRData      CPU load data (always iMemRData)
//   iExt*          external request: valid, we, addr, wdata, byte enables
//   oExtReady      external request accepted this cycle
//   oExtRValid     oExtRData carries external read data this cycle
//   oExtRData      external read data (always iMemRData)
//   oMem*          memory request: en, we, addr, wdata, byte enables
//   iMemRData      memory read data, valid the cycle after a read issue
//-----------------------------------------------------------------------------
module data_memory_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        iClk,
  input  logic        iRst,

  input  logic        iCpuReq,
  input  logic        iCpuWe,
  input  logic [31:0] iCpuAddr,
  input  logic [31:0] iCpuWData,
  input  logic [3:0]  iCpuBe,
  output logic        oCpuStall,
  output logic        oCpuRValid,
  output logic [31:0] oCpuRData,

  input  logic        iExtValid,
  output logic        oExtReady,
  input  logic        iExtWe,
  input  logic [31:0] iExtAddr,
  input  logic [31:0] iExtWData,
  input  logic [3:0]  iExtBe,
  output logic        oExtRValid,
  output logic [31:0] oExtRData,

  output logic        oMemEn,
  output logic        oMemWe,
  output logic [31:0] oMemAddr,
  output logic [31:0] oMemWData,
  output logic [3:0]  oMemBe,
  input  logic [31:0] iMemRData
);

  logic       cpuGrant;
  logic       extGrant;

  // Read-return tag: bit 1 marks a CPU read in flight, bit 0 an external read.
  logic [1:0] rdTag_q;
  logic [1:0] rdTag_d;

`ifdef ARB_STARVE_GUARD_EN
  localparam int              CntW   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

  logic [CntW-1:0] starveCnt_q;
  logic [CntW-1:0] starveCnt_d;
  logic            extForce;

  // The external port has been passed over STARVE_LIMIT times in a row.
  assign extForce = (starveCnt_q == CntMax);

  // Grant decision. Both grants are held low while reset is asserted, so no
  // memory access can leak out during reset. Under contention the CPU wins
  // unless the starvation counter has reached its limit.
  always_comb begin
    cpuGrant = 1'b0;
    extGrant = 1'b0;
    if (!iRst) begin
      if (iCpuReq && iExtValid) begin
        cpuGrant = !extForce;
        extGrant = extForce;
      end else begin
        cpuGrant = iCpuReq;
        extGrant = iExtValid;
      end
    end
  end

  // Starvation counter next state. It counts contended CPU wins and saturates
  // at the limit. It restarts whenever the external port is served or stops
  // asking.
  always_comb begin
    starveCnt_d = starveCnt_q;
    if (extGrant || !iExtValid) begin
      starveCnt_d = '0;
    end else if (cpuGrant && (starveCnt_q != CntMax)) begin
      starveCnt_d = starveCnt_q + CntW'(1);
    end
  end

  // Starvation counter register.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      starveCnt_q <= '0;
    end else begin
      starveCnt_q <= starveCnt_d;
    end
  end
`else
  // Strict CPU priority: the external port only gets idle CPU cycles. Grants
  // are held low during reset.
  always_comb begin
    cpuGrant = !iRst && iCpuReq;
    extGrant = !iRst && iExtValid && !iCpuReq;
  end
`endif

  // Route the granted requester onto the memory port. With no grant the
  // command fields are driven to zero, so an idle port never shows a write.
  always_comb begin
    oMemWe    = 1'b0;
    oMemAddr  = '0;
    oMemWData = '0;
    oMemBe    = '0;
    if (extGrant) begin
      oMemWe    = iExtWe;
      oMemAddr  = iExtAddr;
      oMemWData = iExtWData;
      oMemBe    = iExtBe;
    end else if (cpuGrant) begin
      oMemWe    = iCpuWe;
      oMemAddr  = iCpuAddr;
      oMemWData = iCpuWData;
      oMemBe    = iCpuBe;
    end
  end

  assign oMemEn    = cpuGrant | extGrant;
  assign oCpuStall = iCpuReq & ~cpuGrant;
  assign oExtReady = extGrant;

  // A tag bit is set only for a read granted this cycle. Writes and idle
  // cycles clear it, so each read produces exactly one return flag.
  assign rdTag_d = {cpuGrant & ~iCpuWe, extGrant & ~iExtWe};

  // Read-return tag register. Reset clears it asynchronously, so a read
  // issued just before reset is dropped.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      rdTag_q <= '0;
    end else begin
      rdTag_q <= rdTag_d;
    end
  end

  // Both return buses carry the memory data. The valid flags tell each
  // consumer whether the data belongs to it.
  assign oCpuRValid = rdTag_q[1];
  assign oExtRValid = rdTag_q[0];
  assign oCpuRData  = iMemRData;
  assign oExtRData  = iMemRData;

endmodule
